// File: rtl/mux_scan.sv
// mux_scan: N-channel registered mux with manual select and masked round-robin scan.
// Ports: clk/rst (sync, active-high); mode 0=manual (sel_in) 1=scan (en_mask, DWELL cycles per channel);
// din packs channel i at din[i*W +: W]; dout/sel_out/valid are registered together; wrap pulses when a scan advance wraps.
module mux_scan #(
  parameter int N = 4,
  parameter int W = 1,
  parameter int DWELL = 5,
  localparam int SW = $clog2(N),
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [SW-1:0]  sel_in,
  input  logic [N-1:0]   en_mask,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout,
  output logic [SW-1:0]  sel_out,
  output logic           valid,
  output logic           wrap
);
  logic [W-1:0] ch [N];
  logic [SW-1:0] sel_q, sel_d, nxt;
  logic [W-1:0] dout_q, dout_d;
  logic valid_q, valid_d, wrap_q, wrap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW:0] s;
  logic any, adv, in_ok, scan;
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch[i] = din[i*W +: W];
  end
  // Walk downward so the nearest enabled channel above sel_q (circularly) is the last write.
  always_comb begin
    nxt = sel_q;
    s = '0;
    for (int k = N; k >= 1; k--) begin
      s = {1'b0, sel_q} + (SW+1)'(k);
      s = s >= (SW+1)'(N) ? s - (SW+1)'(N) : s;
      if (en_mask[s[SW-1:0]]) nxt = s[SW-1:0];
    end
  end
  assign any = |en_mask;
  assign in_ok = {1'b0, sel_in} < (SW+1)'(N);
  assign scan = mode && any;
  // A disabled current channel forces an advance; coinciding with dwell expiry it is still one advance.
  assign adv = cnt_q == CW'(DWELL - 1) || !en_mask[sel_q];
  assign sel_d = !mode ? (in_ok ? sel_in : sel_q) : (scan && adv ? nxt : sel_q);
  assign valid_d = mode ? any : in_ok;
  assign dout_d = valid_d ? ch[sel_d] : '0;
  assign cnt_d = scan && !adv ? cnt_q + 1'b1 : '0;
  assign wrap_d = scan && adv && nxt <= sel_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      dout_q <= '0;
      valid_q <= 1'b0;
      wrap_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      dout_q <= dout_d;
      valid_q <= valid_d;
      wrap_q <= wrap_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = dout_q;
  assign sel_out = sel_q;
  assign valid = valid_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: directed vector bench for mux_scan (N=4/W=1/DWELL=5 and N=3/W=2/DWELL=1).
module tb_mux_scan;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, mode_a = 1'b1;
  logic [1:0] sel_a = '0;
  logic [3:0] mask_a = 4'hf, din_a = 4'b0110;
  logic dout_a, valid_a, wrap_a;
  logic [1:0] selo_a;

  logic rst_b = 1'b1, mode_b = 1'b0;
  logic [1:0] sel_b = '0;
  logic [2:0] mask_b = 3'b111;
  logic [5:0] din_b = 6'b11_10_01;
  logic [1:0] dout_b, selo_b;
  logic valid_b, wrap_b;

  mux_scan #(.N(4), .W(1), .DWELL(5)) dut_a (
    .clk(clk), .rst(rst_a), .mode(mode_a), .sel_in(sel_a), .en_mask(mask_a), .din(din_a),
    .dout(dout_a), .sel_out(selo_a), .valid(valid_a), .wrap(wrap_a));

  mux_scan #(.N(3), .W(2), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst_b), .mode(mode_b), .sel_in(sel_b), .en_mask(mask_b), .din(din_b),
    .dout(dout_b), .sel_out(selo_b), .valid(valid_b), .wrap(wrap_b));

  typedef struct {
    int n;
    logic r, m;
    logic [1:0] s;
    logic [3:0] k, d;
    logic od;
    logic [1:0] os;
    logic ov, ow;
  } vec_t;
  vec_t tv[$];
  int checks = 0, errors = 0;

  function automatic void add(int n, logic r, logic m, logic [1:0] s, logic [3:0] k, logic [3:0] d,
                              logic od, logic [1:0] os, logic ov, logic ow);
    tv.push_back('{n, r, m, s, k, d, od, os, ov, ow});
  endfunction

  task automatic chk(string nm, int idx, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got {dout,sel,valid,wrap}=%b required %b", nm, idx, act, exp);
    end
  endtask

  task automatic step_b(int idx, logic r, logic m, logic [1:0] s, logic [2:0] k, logic [5:0] exp);
    @(negedge clk);
    rst_b = r; mode_b = m; sel_b = s; mask_b = k;
    @(posedge clk);
    #1;
    chk("b", idx, {2'b00, dout_b, selo_b, valid_b, wrap_b}, {2'b00, exp});
  endtask

  localparam logic [3:0] F = 4'hf, A = 4'b1010;

  initial begin
    add(2, 1, 1, 0, F, 4'b0110, 0, 0, 0, 0);
    add(4, 0, 1, 0, F, A, 0, 0, 1, 0);
    add(5, 0, 1, 0, F, A, 1, 1, 1, 0);
    add(5, 0, 1, 0, F, A, 0, 2, 1, 0);
    add(5, 0, 1, 0, F, A, 1, 3, 1, 0);
    add(1, 0, 1, 0, F, A, 0, 0, 1, 1);
    add(4, 0, 1, 0, F, A, 0, 0, 1, 0);
    add(5, 0, 1, 0, 4'b1010, A, 1, 1, 1, 0);
    add(5, 0, 1, 0, 4'b1010, A, 1, 3, 1, 0);
    add(1, 0, 1, 0, 4'b1010, A, 1, 1, 1, 1);
    add(4, 0, 1, 0, 4'b1010, A, 1, 1, 1, 0);
    add(5, 0, 1, 0, 4'b1010, A, 1, 3, 1, 0);
    add(1, 0, 1, 0, 4'b1010, A, 1, 1, 1, 1);
    add(2, 0, 1, 0, 4'b1010, 4'b0101, 0, 1, 1, 0);
    add(3, 0, 1, 0, 4'b0000, A, 0, 1, 0, 0);
    add(5, 0, 1, 0, 4'b0100, 4'b0100, 1, 2, 1, 0);
    add(1, 0, 1, 0, 4'b0100, 4'b0100, 1, 2, 1, 1);
    add(4, 0, 1, 0, 4'b0100, 4'b0100, 1, 2, 1, 0);
    add(1, 0, 1, 0, 4'b0100, 4'b0100, 1, 2, 1, 1);
    add(2, 0, 1, 0, F, A, 0, 2, 1, 0);
    add(1, 0, 0, 3, F, A, 1, 3, 1, 0);
    add(4, 0, 1, 0, F, A, 1, 3, 1, 0);
    add(1, 0, 1, 0, F, A, 0, 0, 1, 1);
    add(2, 0, 1, 0, F, A, 0, 0, 1, 0);
    add(1, 1, 1, 0, F, A, 0, 0, 0, 0);
    add(4, 0, 1, 0, F, A, 0, 0, 1, 0);
    add(1, 0, 1, 0, F, A, 1, 1, 1, 0);
    add(1, 0, 0, 0, F, A, 0, 0, 1, 0);
    add(1, 0, 0, 1, 4'b0000, A, 1, 1, 1, 0);
    add(1, 0, 0, 2, 4'b0000, A, 0, 2, 1, 0);
    add(1, 0, 0, 3, F, A, 1, 3, 1, 0);
    add(4, 0, 1, 0, F, A, 1, 3, 1, 0);
    add(1, 0, 0, 3, F, A, 1, 3, 1, 0);
    add(4, 0, 1, 0, F, A, 1, 3, 1, 0);
    add(1, 0, 1, 0, F, A, 0, 0, 1, 1);
    foreach (tv[i]) begin
      for (int c = 0; c < tv[i].n; c++) begin
        @(negedge clk);
        rst_a = tv[i].r; mode_a = tv[i].m; sel_a = tv[i].s; mask_a = tv[i].k; din_a = tv[i].d;
        @(posedge clk);
        #1;
        chk("a", i, {3'b000, dout_a, selo_a, valid_a, wrap_a},
            {3'b000, tv[i].od, tv[i].os, tv[i].ov, tv[i].ow});
      end
    end
    step_b(0, 1, 0, 0, 3'b111, {2'b00, 2'd0, 1'b0, 1'b0});
    step_b(1, 0, 0, 2, 3'b111, {2'b11, 2'd2, 1'b1, 1'b0});
    step_b(2, 0, 0, 3, 3'b111, {2'b00, 2'd2, 1'b0, 1'b0});
    step_b(3, 0, 1, 0, 3'b111, {2'b01, 2'd0, 1'b1, 1'b1});
    step_b(4, 0, 1, 0, 3'b111, {2'b10, 2'd1, 1'b1, 1'b0});
    step_b(5, 0, 1, 0, 3'b111, {2'b11, 2'd2, 1'b1, 1'b0});
    step_b(6, 0, 1, 0, 3'b111, {2'b01, 2'd0, 1'b1, 1'b1});
    step_b(7, 0, 1, 0, 3'b101, {2'b11, 2'd2, 1'b1, 1'b0});
    step_b(8, 0, 1, 0, 3'b101, {2'b01, 2'd0, 1'b1, 1'b1});
    step_b(9, 0, 0, 1, 3'b101, {2'b10, 2'd1, 1'b1, 1'b0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised N-channel, W-bit registered multiplexer with two modes: manual select and automatic round-robin scan. Scan mode holds each channel for a fixed dwell time, skips masked channels, and flags wrap-around. It is the clocked successor to the combinational 4-to-1 selector. It sits between a bank of parallel sources and a single shared downstream sink, such as a display, serial link or monitor.

## Interface
- N, default 4: channel count, must be at least 2.
- W, default 1: channel data width, must be at least 1.
- DWELL, default 5: cycles each channel is held in scan mode, must be at least 1.
- SW, derived, not overridable: select width, $clog2(N).

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = manual, 1 = scan.
- sel_in  input  SW  channel index used in manual mode.
- en_mask  input  N  per-channel enable used in scan mode; bit i enables channel i.
- din  input  N*W  channel i occupies din[i*W +: W].
- dout  output  W  registered selected data.
- sel_out  output  SW  registered index of the channel shown on dout.
- valid  output  1  dout holds data from a legal, enabled channel.
- wrap  output  1  one-cycle pulse when a scan advance passes index N-1.

## Operation
- Reset: sel_out=0, dout=0, valid=0, wrap=0, dwell counter=0. Reset overrides every other input.
- dout, sel_out and valid are registered together and are always mutually consistent. dout = din[sel_out] as sampled at the same edge.
- Manual mode (mode=0):
  - If sel_in < N: sel_out <= sel_in, dout <= din[sel_in], valid <= 1.
  - If sel_in >= N (non-power-of-2 N only): sel_out holds, dout <= 0, valid <= 0.
  - en_mask is ignored. The dwell counter is held at 0. wrap=0.
- Scan mode (mode=1):
  - The dwell counter counts 0..DWELL-1.
  - Advance occurs at the edge where the counter equals DWELL-1. On advance, sel_out moves to the next enabled index searching upward circularly from sel_out+1, and the counter returns to 0.
  - Forced advance: if en_mask[sel_out]=0, advance at the next edge regardless of the counter.
  - wrap <= 1 for exactly one cycle when the new index is less than or equal to the old index.
  - A single enabled channel equal to sel_out re-selects itself, with wrap=1 once per dwell period.
  - en_mask all zero: sel_out holds, dout <= 0, valid <= 0, wrap=0, counter held at 0.
  - Otherwise valid <= 1, and dout tracks din[sel_out] every cycle, so live changes on din propagate during the dwell period.
- Mode switches:
  - Manual to scan: the counter starts from 0 and scan begins at the current sel_out.
  - Scan to manual: sel_out = sel_in at the next edge, and any pending wrap is dropped.
- en_mask changes take effect at the next edge. Clearing the current channel's bit triggers a forced advance.

## Timing
- Input-to-output latency is 1 clock for data, select and mask in both modes. There is no combinational path from inputs to outputs.
- Scan period: each enabled channel is held exactly DWELL cycles. A full sweep of k enabled channels takes k*DWELL cycles.
- DWELL=1: advance every cycle. With all channels enabled, sel_out runs 0,1,…,N-1,0 with wrap asserted on each return to 0.
- Reset asserted mid-scan: all outputs reach their reset values at that edge. After rst falls, the scan restarts from channel 0 with a full dwell.
- Simultaneous forced advance and dwell expiry: a single advance only.

## Test plan
- Reset: rst=1 for 2 cycles with random din -> dout=0, sel_out=0, valid=0, wrap=0. Release in scan mode with all channels enabled -> sel_out=0 for 5 cycles.
- Manual: N=4, W=1, din=4'b1010, sel_in=0,1,2,3 on successive cycles -> dout=0,1,0,1 one cycle later, valid=1 throughout, wrap=0.
- Full scan: mode=1, en_mask=4'b1111, DWELL=5, din=4'b1010 -> sel_out holds 0,1,2,3 for 5 cycles each then returns to 0. dout=0,1,0,1. wrap=1 only in the first cycle of the return to 0.
- Masked scan: en_mask=4'b1010 -> sel_out sequence 1,3,1,3, each held 5 cycles, wrap on each 3->1. Starting from sel_out=0, a forced advance to 1 occurs after 1 cycle.
- Empty mask: en_mask=0 -> valid=0, dout=0, sel_out held. Then set en_mask=4'b0100 -> sel_out=2, valid=1 after 1 cycle. Further advances re-select 2 with wrap every 5 cycles.
- Mode and reset interplay: switch scan to manual mid-dwell with sel_in=3 -> sel_out=3 next cycle. Back to scan -> 3 is held 5 cycles. Assert rst on dwell cycle 2 -> all outputs reset at that edge and the scan restarts from channel 0.
